act_skew_feeder: RTL and testbench
==================================

Name: act_skew_feeder

Overview:
- Sits directly downstream of the activation mux and consumes its 4-lane activation stream (act_data_1..4, act_valid/act_ready).
- Produces the diagonally skewed feed the systolic PE array needs: lane k is delayed by k extra cycles relative to lane 0, with zero-filled bubbles.
- Counts a configured number of input beats, then flushes the skew pipeline so the last element reaches every lane.
- Flags the final element on the last lane.

Parameters:
- DATA_W, `DATA_ACT_WIDTH` (12), width of one activation lane.
- LANES, 4, number of lanes. The design is fixed at 4; the parameter exists only for readability and the assertion check.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- s_config_valid  in  1  config word valid.
- s_config_ready  out  1  config accepted when high.
- s_config_data  in  32  total_len, the number of input beats in this job.
- act_data_1..act_data_4  in  DATA_W each  activation lanes from the mux.
- act_valid  in  1  activation beat valid.
- act_ready  out  1  feeder accepts the beat.
- pe_data_1..pe_data_4  out  DATA_W each  skewed lanes to the PE array row inputs.
- pe_valid_1..pe_valid_4  out  1 each  per-lane valid.
- pe_ready  in  1  array advance enable; when low, all outputs hold.
- pe_last  out  1  high alongside the final element on lane 4.
- status_skew  out  2  current state encoding.

Behaviour:
- States and encodings: IDLE=0, RUN=1, FLUSH=2.
- Reset (rst_n low at posedge):
  - state=IDLE, s_config_ready=1.
  - All delay stages and output registers cleared: every pe_data=0, every pe_valid=0, pe_last=0.
  - beat counter and flush counter = 0.
  - Reset mid-job discards all in-flight data; no partial flush occurs.
- IDLE:
  - s_config_ready=1, act_ready=0, no advance.
  - A config handshake with s_config_data != 0 latches total_len, clears beat_cnt, and moves to RUN next cycle. s_config_ready drops in that same next cycle.
  - A handshake with s_config_data == 0 is consumed and ignored; the block stays in IDLE.
- Advance signal: adv = pe_ready & (state==RUN | state==FLUSH). Every register in the skew pipeline updates only when adv=1; otherwise everything holds.
- RUN:
  - act_ready = pe_ready (combinational).
  - Accept = act_valid & act_ready.
  - On each adv, lane 0 input = act_data_1 with valid=accept. Lane k (k=2..4) input = act_data_k with the same valid, entering a (k-1)-stage delay chain.
  - When valid=0, a bubble with data forced to 0 enters all lanes. Bubbles keep the skew aligned.
  - On each accept, beat_cnt increments. The accept where beat_cnt+1 == total_len moves the state to FLUSH.
- Latency, counted in adv cycles from the accept edge to the output register: lane 1 = 1, lane 2 = 2, lane 3 = 3, lane 4 = 4.
- Output encoding: pe_valid_k mirrors its stage valid, and pe_data_k is 0 whenever pe_valid_k=0.
- FLUSH:
  - act_ready=0.
  - Each adv injects a bubble.
  - After exactly LANES-1 = 3 adv cycles the state goes to IDLE and s_config_ready returns to 1. The final element then sits on lane 4's output register.
  - Output registers hold the last values until the next job's adv; they do not auto-clear.
- pe_last is carried in a side bit on the lane-4 chain. It is set for the beat that completed total_len and is high exactly when that beat is on pe_data_4/pe_valid_4.
- Simultaneous events:
  - pe_ready falling in the same cycle as the final accept: the accept still counts, and the state enters FLUSH with the pipeline frozen until pe_ready returns.
  - Config handshake during RUN/FLUSH is impossible because ready is low.
- Width rules: beat_cnt is 32 bits and compared with equality against total_len only. The flush counter is 2 bits.

Decomposition:
- Shared package / DEFINE.vh:
  - `DATA_ACT_WIDTH (already present).
  - State encodings SKEW_IDLE/SKEW_RUN/SKEW_FLUSH.
  - SKEW_LANES=4.
- Sub-module: skew_delay_line (parameters DEPTH, W).
  - A DEPTH-stage register chain with common enable and synchronous clear, carrying {last, valid, data}.
  - Instantiated for lanes 2–4 with DEPTH 1, 2, 3. Lane 1 uses only the output register.

Test Plan:
1. Config total_len=4, pe_ready=1. Feed beats where lane k of beat n = 16·n+k, for n=0..3. Required response:
   - pe_data_1 shows 0,16,32,48 on adv cycles 1–4.
   - pe_data_4 shows 3,19,35,51 on cycles 4–7.
   - pe_last=1 only with 51.
   - State returns to IDLE after cycle 7.
2. Same job with act_valid low on the cycle after the 2nd beat. Required response: a zero/valid=0 bubble appears on every lane at its skewed slot, and the diagonal stays intact.
3. pe_ready held low for 5 cycles mid-RUN. Required response: all pe_* outputs and act_ready hold, and no beat is lost or duplicated.
4. Config s_config_data=0. Required response: the handshake completes, the state stays IDLE, and s_config_ready stays 1.
5. rst_n low for 1 cycle during FLUSH of a total_len=3 job. Required response: all outputs are 0 next cycle, the state is IDLE, and a subsequent total_len=1 job yields pe_last with pe_data_4 on adv cycle 4.
6. Two back-to-back jobs with total_len=2 each. Required response: the second config is accepted only after FLUSH completes, and output sequences match the golden skew model.

Source files
------------

// File: rtl/act_skew_feeder_pkg.sv
// Shared constants and state encoding for the activation skew feeder.
package act_skew_feeder_pkg;

   localparam int DATA_ACT_WIDTH = 12;
   localparam int SKEW_LANES     = 4;

   typedef enum logic [1:0] {
      SKEW_IDLE  = 2'd0,
      SKEW_RUN   = 2'd1,
      SKEW_FLUSH = 2'd2
   } skew_state_e;

endpackage

// File: rtl/act_skew_feeder_if.sv
// Config, activation and PE-row signals of the skew feeder, bundled with both viewpoints.
interface act_skew_feeder_if
   import act_skew_feeder_pkg::*;
#(
   parameter int DATA_W = DATA_ACT_WIDTH
);

   logic              s_config_valid;
   logic              s_config_ready;
   logic [31:0]       s_config_data;

   logic [DATA_W-1:0] act_data_1;
   logic [DATA_W-1:0] act_data_2;
   logic [DATA_W-1:0] act_data_3;
   logic [DATA_W-1:0] act_data_4;
   logic              act_valid;
   logic              act_ready;

   logic [DATA_W-1:0] pe_data_1;
   logic [DATA_W-1:0] pe_data_2;
   logic [DATA_W-1:0] pe_data_3;
   logic [DATA_W-1:0] pe_data_4;
   logic              pe_valid_1;
   logic              pe_valid_2;
   logic              pe_valid_3;
   logic              pe_valid_4;
   logic              pe_ready;
   logic              pe_last;
   logic [1:0]        status_skew;

   // The feeder itself.
   modport slave (
      input  s_config_valid, s_config_data,
      input  act_data_1, act_data_2, act_data_3, act_data_4, act_valid,
      input  pe_ready,
      output s_config_ready, act_ready,
      output pe_data_1, pe_data_2, pe_data_3, pe_data_4,
      output pe_valid_1, pe_valid_2, pe_valid_3, pe_valid_4,
      output pe_last, status_skew
   );

   // The surrounding logic: mux, config source and PE array.
   modport master (
      output s_config_valid, s_config_data,
      output act_data_1, act_data_2, act_data_3, act_data_4, act_valid,
      output pe_ready,
      input  s_config_ready, act_ready,
      input  pe_data_1, pe_data_2, pe_data_3, pe_data_4,
      input  pe_valid_1, pe_valid_2, pe_valid_3, pe_valid_4,
      input  pe_last, status_skew
   );

endinterface

// File: rtl/act_skew_feeder_skew_delay_line.sv
// DEPTH-stage register chain with a shared enable and synchronous clear.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_reg [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else if (en) begin
         stage_reg[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Turns the 4-lane activation stream into the diagonal feed of a systolic row:
// lane k lags lane 0 by k advances, and a job is flushed so its last beat reaches lane 4.
module act_skew_feeder
   import act_skew_feeder_pkg::*;
#(
   parameter int DATA_W = DATA_ACT_WIDTH,
   parameter int LANES  = SKEW_LANES
) (
   input  logic             clk,
   input  logic             rst_n,
   act_skew_feeder_if.slave bus
);

   genvar gi;

   if (LANES != 4) begin : g_lanes_check
      $error("act_skew_feeder is built for exactly 4 lanes");
   end

   skew_state_e       state_reg;
   logic              cfg_ready_reg;
   logic [31:0]       total_len_reg;
   logic [31:0]       beat_cnt_reg;
   logic [1:0]        flush_cnt_reg;

   logic              adv;
   logic              accept;
   logic              last_beat;
   logic              clr;

   logic [DATA_W-1:0] act_data  [LANES];
   logic [DATA_W-1:0] lane_in   [LANES];
   logic [DATA_W-1:0] stage_data[LANES];
   logic              stage_valid[LANES];
   logic              stage_last;

   logic [DATA_W-1:0] pe_data_reg [LANES];
   logic              pe_valid_reg[LANES];
   logic              pe_last_reg;

   assign clr       = ~rst_n;
   assign adv       = bus.pe_ready & ((state_reg == SKEW_RUN) | (state_reg == SKEW_FLUSH));
   assign accept    = (state_reg == SKEW_RUN) & bus.act_valid & bus.pe_ready;
   assign last_beat = accept & ((beat_cnt_reg + 32'd1) == total_len_reg);

   assign act_data[0] = bus.act_data_1;
   assign act_data[1] = bus.act_data_2;
   assign act_data[2] = bus.act_data_3;
   assign act_data[3] = bus.act_data_4;

   // Anything not accepted enters as a zero bubble so the diagonal never slips.
   for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_in[gi] = accept ? act_data[gi] : '0;

      if (gi == 0) begin : g_direct
         assign stage_data[gi]  = lane_in[gi];
         assign stage_valid[gi] = accept;
      end else if (gi == LANES - 1) begin : g_tail
         logic [DATA_W+1:0] tail_q;
         skew_delay_line #(.DEPTH(gi), .W(DATA_W + 2)) u_delay (
            .clk (clk),
            .clr (clr),
            .en  (adv),
            .d   ({last_beat, accept, lane_in[gi]}),
            .q   (tail_q)
         );
         assign stage_last      = tail_q[DATA_W+1];
         assign stage_valid[gi] = tail_q[DATA_W];
         assign stage_data[gi]  = tail_q[DATA_W-1:0];
      end else begin : g_mid
         logic [DATA_W:0] mid_q;
         skew_delay_line #(.DEPTH(gi), .W(DATA_W + 1)) u_delay (
            .clk (clk),
            .clr (clr),
            .en  (adv),
            .d   ({accept, lane_in[gi]}),
            .q   (mid_q)
         );
         assign stage_valid[gi] = mid_q[DATA_W];
         assign stage_data[gi]  = mid_q[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            pe_data_reg[i]  <= '0;
            pe_valid_reg[i] <= 1'b0;
         end
         pe_last_reg <= 1'b0;
      end else if (adv) begin
         for (int i = 0; i < LANES; i++) begin
            pe_data_reg[i]  <= stage_valid[i] ? stage_data[i] : '0;
            pe_valid_reg[i] <= stage_valid[i];
         end
         pe_last_reg <= stage_last;
      end
   end

   // Flush needs LANES-1 advances for the final beat to walk down lane 4.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= SKEW_IDLE;
         cfg_ready_reg <= 1'b1;
         total_len_reg <= '0;
         beat_cnt_reg  <= '0;
         flush_cnt_reg <= '0;
      end else begin
         case (state_reg)
            SKEW_IDLE: begin
               if (bus.s_config_valid && (bus.s_config_data != 32'd0)) begin
                  total_len_reg <= bus.s_config_data;
                  beat_cnt_reg  <= '0;
                  state_reg     <= SKEW_RUN;
                  cfg_ready_reg <= 1'b0;
               end
            end
            SKEW_RUN: begin
               if (accept) begin
                  beat_cnt_reg <= beat_cnt_reg + 32'd1;
                  if (last_beat) begin
                     state_reg     <= SKEW_FLUSH;
                     flush_cnt_reg <= '0;
                  end
               end
            end
            SKEW_FLUSH: begin
               if (adv) begin
                  if (flush_cnt_reg == 2'(LANES - 2)) begin
                     state_reg     <= SKEW_IDLE;
                     cfg_ready_reg <= 1'b1;
                     flush_cnt_reg <= '0;
                  end else begin
                     flush_cnt_reg <= flush_cnt_reg + 2'd1;
                  end
               end
            end
            default: begin
               state_reg     <= SKEW_IDLE;
               cfg_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign bus.s_config_ready = cfg_ready_reg;
   assign bus.act_ready      = (state_reg == SKEW_RUN) & bus.pe_ready;
   assign bus.status_skew    = state_reg;
   assign bus.pe_data_1      = pe_data_reg[0];
   assign bus.pe_data_2      = pe_data_reg[1];
   assign bus.pe_data_3      = pe_data_reg[2];
   assign bus.pe_data_4      = pe_data_reg[3];
   assign bus.pe_valid_1     = pe_valid_reg[0];
   assign bus.pe_valid_2     = pe_valid_reg[1];
   assign bus.pe_valid_3     = pe_valid_reg[2];
   assign bus.pe_valid_4     = pe_valid_reg[3];
   assign bus.pe_last        = pe_last_reg;

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder: a history-buffer model of the skew predicts
// every cycle's outputs, and a monitor compares them after each rising edge.
module tb_act_skew_feeder;

   localparam int W = 12;

   typedef struct packed {
      logic [3:0]        v;
      logic [3:0][W-1:0] d;
      logic              last;
      logic              ar;
      logic              cr;
      logic [1:0]        st;
   } exp_t;

   logic clk;
   logic rst_n;

   act_skew_feeder_if #(.DATA_W(W)) bus ();

   act_skew_feeder #(.DATA_W(W), .LANES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: job bookkeeping plus the last four injected items per advance.
   int          m_mode;
   logic [31:0] m_total;
   logic [31:0] m_cnt;
   int          m_fl;
   logic        h_v   [4];
   logic        h_l   [4];
   logic [W-1:0] h_d  [4][4];
   logic [3:0]        o_v;
   logic [3:0][W-1:0] o_d;
   logic              o_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input logic rn, input logic cv, input logic [31:0] cd, input logic av,
                       input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [W-1:0] a2, input logic [W-1:0] a3, input logic pr);
      exp_t e;
      logic inj_v;
      logic inj_l;
      logic [W-1:0] inj_d [4];
      @(negedge clk);
      rst_n              = rn;
      bus.s_config_valid = cv;
      bus.s_config_data  = cd;
      bus.act_valid      = av;
      bus.act_data_1     = a0;
      bus.act_data_2     = a1;
      bus.act_data_3     = a2;
      bus.act_data_4     = a3;
      bus.pe_ready       = pr;
      if (!rn) begin
         m_mode = 0; m_total = '0; m_cnt = '0; m_fl = 0;
         for (int k = 0; k < 4; k++) begin
            h_v[k] = 1'b0; h_l[k] = 1'b0;
            for (int j = 0; j < 4; j++) h_d[k][j] = '0;
         end
         o_v = '0; o_d = '0; o_last = 1'b0;
      end else if (m_mode == 0) begin
         if (cv && cd != 32'd0) begin
            m_total = cd; m_cnt = '0; m_mode = 1;
         end
      end else if (pr) begin
         inj_v = 1'b0; inj_l = 1'b0;
         for (int j = 0; j < 4; j++) inj_d[j] = '0;
         if (m_mode == 1 && av) begin
            inj_v = 1'b1;
            inj_d[0] = a0; inj_d[1] = a1; inj_d[2] = a2; inj_d[3] = a3;
            m_cnt = m_cnt + 32'd1;
            $display("beat %0d/%0d lanes %03h %03h %03h %03h", m_cnt, m_total, a0, a1, a2, a3);
            if (m_cnt == m_total) begin
               inj_l = 1'b1; m_mode = 2; m_fl = 3;
            end
         end else if (m_mode == 2) begin
            m_fl--;
            if (m_fl == 0) m_mode = 0;
         end
         for (int k = 3; k > 0; k--) begin
            h_v[k] = h_v[k-1]; h_l[k] = h_l[k-1];
            for (int j = 0; j < 4; j++) h_d[k][j] = h_d[k-1][j];
         end
         h_v[0] = inj_v; h_l[0] = inj_l;
         for (int j = 0; j < 4; j++) h_d[0][j] = inj_d[j];
         // Lane k shows what was injected k advances ago.
         for (int k = 0; k < 4; k++) begin
            o_v[k] = h_v[k];
            o_d[k] = h_d[k][k];
         end
         o_last = h_l[3];
      end
      e.v = o_v; e.d = o_d; e.last = o_last;
      e.ar = (m_mode == 1) && pr;
      e.cr = (m_mode == 0);
      e.st = 2'(m_mode);
      expq.push_back(e);
   endtask

   task automatic idle_step(input logic pr);
      step(1'b1, 1'b0, 32'd0, 1'b0, '0, '0, '0, '0, pr);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (m_mode != 0 && i < 20) begin
         idle_step(1'b1);
         i++;
      end
      if (m_mode != 0) begin
         errors++;
         $display("FAIL job_drain actual=%0d required=0", m_mode);
      end
   endtask

   task automatic beat(input int n, input bit rnd, input logic pr);
      logic [W-1:0] d [4];
      for (int k = 0; k < 4; k++)
         d[k] = rnd ? W'($urandom) : W'(16 * n + k);
      step(1'b1, 1'b0, 32'd0, 1'b1, d[0], d[1], d[2], d[3], pr);
   endtask

   task automatic do_job(input int len, input int gap_after, input int stall_at,
                         input int stall_len, input bit rnd);
      step(1'b1, 1'b1, 32'(len), 1'b0, '0, '0, '0, '0, 1'b1);
      for (int n = 0; n < len; n++) begin
         if (n == stall_at)
            for (int s = 0; s < stall_len; s++) beat(n, 1'b0, 1'b0);
         beat(n, rnd, 1'b1);
         if (n + 1 == gap_after) idle_step(1'b1);
      end
      wait_idle();
      idle_step(1'b1);
      idle_step(1'b1);
   endtask

   // Monitor: every rising edge has exactly one predicted output set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("pe_valid_1", 32'(bus.pe_valid_1), 32'(e.v[0]));
            chk("pe_valid_2", 32'(bus.pe_valid_2), 32'(e.v[1]));
            chk("pe_valid_3", 32'(bus.pe_valid_3), 32'(e.v[2]));
            chk("pe_valid_4", 32'(bus.pe_valid_4), 32'(e.v[3]));
            chk("pe_data_1", 32'(bus.pe_data_1), 32'(e.d[0]));
            chk("pe_data_2", 32'(bus.pe_data_2), 32'(e.d[1]));
            chk("pe_data_3", 32'(bus.pe_data_3), 32'(e.d[2]));
            chk("pe_data_4", 32'(bus.pe_data_4), 32'(e.d[3]));
            chk("pe_last", 32'(bus.pe_last), 32'(e.last));
            chk("act_ready", 32'(bus.act_ready), 32'(e.ar));
            chk("s_config_ready", 32'(bus.s_config_ready), 32'(e.cr));
            chk("status_skew", 32'(bus.status_skew), 32'(e.st));
         end
      end
   end

   initial begin
      int i;
      rst_n = 1'b0;
      bus.s_config_valid = 1'b0; bus.s_config_data = '0;
      bus.act_valid = 1'b0; bus.pe_ready = 1'b0;
      bus.act_data_1 = '0; bus.act_data_2 = '0; bus.act_data_3 = '0; bus.act_data_4 = '0;

      step(1'b0, 1'b0, 32'd0, 1'b0, '0, '0, '0, '0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, '0, '0, '0, '0, 1'b1);
      idle_step(1'b1);

      do_job(4, -1, -1, 0, 1'b0);
      do_job(4, 2, -1, 0, 1'b0);
      do_job(4, -1, 2, 5, 1'b0);

      step(1'b1, 1'b1, 32'd0, 1'b0, '0, '0, '0, '0, 1'b1);
      idle_step(1'b1);

      // Reset lands in the middle of the flush of a three-beat job.
      step(1'b1, 1'b1, 32'd3, 1'b0, '0, '0, '0, '0, 1'b1);
      for (int n = 0; n < 3; n++) beat(n, 1'b0, 1'b1);
      idle_step(1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, '0, '0, '0, '0, 1'b1);
      idle_step(1'b1);
      do_job(1, -1, -1, 0, 1'b0);

      // Second config is held valid throughout the first job's flush.
      step(1'b1, 1'b1, 32'd2, 1'b0, '0, '0, '0, '0, 1'b1);
      beat(0, 1'b1, 1'b1);
      beat(1, 1'b1, 1'b1);
      i = 0;
      while (m_mode != 1 && i < 10) begin
         step(1'b1, 1'b1, 32'd2, 1'b0, '0, '0, '0, '0, 1'b1);
         i++;
      end
      beat(0, 1'b1, 1'b1);
      beat(1, 1'b1, 1'b1);
      wait_idle();
      idle_step(1'b1);

      for (int c = 0; c < 600; c++) begin
         step(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) == 0),
              32'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0),
              W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              ($urandom_range(0, 4) != 0));
      end
      wait_idle();
      idle_step(1'b1);

      @(posedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
